uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx byte transmitter between several message sources: drive-command bytes from command_translator, distance telemetry and pitch telemetry.
- Grants the UART to one requester for a whole message, delimited by a last flag, using round-robin fairness.
- Holds a one-byte output register toward uart_tx.
- Enforces a stall timeout and a maximum message length so that one source cannot hold the link indefinitely.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 50000, cycles a granted requester may stall mid-message before its grant is revoked (1 ms at 50 MHz)
MAX_LEN, 16, maximum bytes per message; the grant is forced to release after this many bytes

Ports:
clk  in  1  system clock (clk_50 domain)
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  marks the final byte of a message
req_ready  out  NUM_REQ  per-requester accept
tx_data  out  DATA_W  byte to uart_tx
tx_valid  out  1  byte available to uart_tx
tx_ready  in  1  uart_tx idle/accepting
grant_id  out  $clog2(NUM_REQ)  currently or last granted requester
busy  out  1  high while in LOCKED
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout
trunc_pulse  out  1  one-cycle pulse when a grant is released by MAX_LEN without req_last

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - tx_valid=0, tx_data=0, req_ready=0, busy=0, timeout_pulse=0, trunc_pulse=0.
  - grant_id=0; last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - state=IDLE; stall and length counters 0.
- Transfers:
  - Upstream transfer: req_valid[i] && req_ready[i].
  - Downstream transfer: tx_valid && tx_ready.
- IDLE state:
  - req_ready is all zero.
  - If any req_valid is set, select the first asserted index searching from last_grant+1 upward, with wrap.
  - Register the selection to grant_id and go to LOCKED.
  - Arbitration costs exactly one cycle; the first byte can be accepted in the following cycle.
- LOCKED state:
  - req_ready[grant_id] = (!tx_valid || tx_ready). All other req_ready bits are 0.
  - This ready is combinational from tx_ready, giving a 1-entry pipeline.
  - On an upstream transfer: tx_data <= byte, tx_valid <= 1, len <= len+1, stall counter cleared.
  - On a downstream transfer with no upstream transfer in the same cycle: tx_valid <= 0.
  - A downstream and an upstream transfer in the same cycle keep tx_valid=1 with the new data, giving a back-to-back throughput of 1 byte/cycle.
  - The stall counter increments each LOCKED cycle without an upstream transfer.
- Release from LOCKED:
  - (a) Upstream transfer with req_last=1 -> IDLE.
  - (b) Upstream transfer that makes len==MAX_LEN with req_last=0 -> IDLE, trunc_pulse=1 for one cycle.
  - (c) Stall counter reaching TIMEOUT-1 -> IDLE, timeout_pulse=1 for one cycle; no byte is dropped or inserted.
  - On any release: last_grant <= grant_id, len <= 0, stall counter <= 0.
  - If (a) and (b) coincide, the release counts as normal and trunc_pulse stays 0.
- The output register drains independently of state: a pending tx_valid byte stays valid across IDLE and re-arbitration until uart_tx takes it. The next grant's first byte waits on that drain through req_ready.
- tx_data and tx_valid are stable while tx_valid=1 and tx_ready=0.
- grant_id holds its value in IDLE until the next grant. busy = (state==LOCKED).
- A requester dropping req_valid mid-message only advances the stall counter; there is no abort input.
- Reset mid-message discards the pending byte and the grant immediately; tx_valid falls asynchronously.
- Counter widths: len is $clog2(MAX_LEN+1) bits; the stall counter is $clog2(TIMEOUT+1) bits. Neither counter wraps; both saturate at their release condition.

Test Plan:
1. Reset, then req0 sends 3 bytes 0x46,0x57,0x0A (last on 0x0A), tx_ready held 1 -> grant_id=0, tx_data sequence 46,57,0A on consecutive cycles starting 2 cycles after req_valid, busy falls the cycle after 0x0A is accepted.
2. req0, req1 and req2 all valid continuously with 1-byte messages (last=1), tx_ready=1 -> grant order 0,1,2,0,1,2; each message separated by exactly one IDLE cycle.
3. req1 sends 0xAA, tx_ready held 0 for 20 cycles -> tx_valid=1 and tx_data=0xAA stable for 20 cycles, req_ready[1]=0 throughout; on tx_ready=1 the next byte is accepted in the same cycle.
4. TIMEOUT=8: req2 sends 1 byte with last=0, then drops valid -> timeout_pulse after 8 stall cycles, state IDLE, req0 waiting is granted on the next cycle.
5. MAX_LEN=4: req0 streams 6 bytes with last=0 -> 4 bytes accepted, trunc_pulse once, req1 (valid) granted next, and req0 is re-granted only after req1 finishes.
6. Assert reset while LOCKED with tx_valid=1 -> tx_valid, busy and req_ready go 0 asynchronously; after release requester 0 has priority over requester 2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one uart_tx.
// Stall timeout and max-length cap keep one source from holding the link.
// Ports: clk, reset (async, active-high)
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_data/tx_valid/tx_ready             : one-byte register to uart_tx
//   grant_id, busy                        : current/last grant, LOCKED flag
//   timeout_pulse, trunc_pulse            : one-cycle release reasons
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 50000,
  parameter int MAX_LEN = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_pulse,
  output logic                        trunc_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_nx;

  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     pick;
  logic              pick_ok;
  logic [LW-1:0]     len_q;
  logic [SW-1:0]     stall_q;
  logic              slot_free;
  logic              up_xfer;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              rel_last;
  logic              rel_len;
  logic              rel_to;
  logic              release_now;

  assign busy        = (state == LOCKED);
  assign slot_free   = !tx_valid || tx_ready;
  assign up_xfer     = busy && g_valid && slot_free;
  assign release_now = rel_last || rel_len || rel_to;

  // Granted requester's signals; ready is combinational on tx_ready.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = busy && slot_free;
      end
    end
  end

  // Round robin: indices above last_grant beat the wrapped ones;
  // descending loops let the lowest index in each group win.
  always_comb begin
    pick    = last_grant;
    pick_ok = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GW'(i) <= last_grant)) begin
        pick    = GW'(i);
        pick_ok = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GW'(i) > last_grant)) begin
        pick    = GW'(i);
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A last-flagged byte wins over the length cap.
  always_comb begin
    state_nx = state;
    rel_last = 1'b0;
    rel_len  = 1'b0;
    rel_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) state_nx = LOCKED;
      end
      LOCKED: begin
        if (up_xfer) begin
          if (g_last)
            rel_last = 1'b1;
          else if (len_q == LW'(MAX_LEN - 1))
            rel_len = 1'b1;
        end else if (stall_q == SW'(TIMEOUT - 1)) begin
          rel_to = 1'b1;
        end
        if (rel_last || rel_len || rel_to)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id      <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
      len_q         <= '0;
      stall_q       <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      timeout_pulse <= 1'b0;
      trunc_pulse   <= 1'b0;
    end else begin
      timeout_pulse <= rel_to;
      trunc_pulse   <= rel_len;
      if (!busy && pick_ok)
        grant_id <= pick;
      // Output register drains regardless of state.
      if (up_xfer) begin
        tx_data  <= g_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (busy) begin
        if (release_now) begin
          last_grant <= grant_id;
          len_q      <= '0;
          stall_q    <= '0;
        end else if (up_xfer) begin
          len_q   <= len_q + LW'(1);
          stall_q <= '0;
        end else begin
          stall_q <= stall_q + SW'(1);
        end
      end
    end
  end

endmodule
